// File: rtl/rv32i_exec_mem_unit.sv
// RV32I execute/memory slice: main decoder, ALU, word RAM with init write port; optional debug read when RV32I_DEBUG_PORT_EN.
// Latency: decode/ALU/load/debug data are combinational; RAM writes commit on the rising clk edge.
// Backpressure: none, single-cycle datapath with no handshake; every enabled edge writes.
module rv32i_exec_mem_unit #(
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instr,
    input  logic [31:0]           rs1,
    input  logic [31:0]           rs2,
    input  logic [31:0]           imm,
    input  logic                  init_mode,
    input  logic [ADDR_WIDTH-1:0] ext_w_addr,
    input  logic [31:0]           ext_w_dat,
    input  logic                  ext_w_enb,
    output logic                  branch,
    output logic [2:0]            imm_src,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_2_reg,
    output logic                  alu_src,
    output logic                  reg_write,
    output logic [3:0]            alu_ctrl,
    output logic [1:0]            wrt_back_src,
    output logic [31:0]           alu_result,
    output logic                  alu_zero,
    output logic [31:0]           mem_rdata
`ifdef RV32I_DEBUG_PORT_EN
    ,
    input  logic [ADDR_WIDTH-1:0] debug_addr,
    output logic [31:0]           debug_data
`endif
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_SLT = 4'd8, ALU_SLTU = 4'd9
    } alu_op_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       is_br;
    logic       br_inv;
    logic       jump;
    logic [31:0] op_b;

    assign opcode = instr[6:0];
    assign func3  = instr[14:12];
    assign func7  = instr[31:25];

    function automatic logic [3:0] alu_op_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        is_br        = 1'b0;
        br_inv       = 1'b0;
        jump         = 1'b0;
        imm_src      = 3'b000;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_2_reg    = 1'b0;
        alu_src      = 1'b0;
        reg_write    = 1'b0;
        alu_ctrl     = ALU_ADD;
        wrt_back_src = 2'b01;
        if (rst) begin
            wrt_back_src = 2'b00;
        end else begin
            case (opcode)
                OP_R: begin
                    reg_write = 1'b1;
                    alu_ctrl  = alu_op_sel(func3, func7 == F7_ALT);
                end
                // Immediate forms only honour the alternate func7 for the right shift.
                OP_I: begin
                    reg_write = 1'b1;
                    alu_src   = 1'b1;
                    alu_ctrl  = alu_op_sel(func3, (func7 == F7_ALT) && (func3 == 3'b101));
                end
                OP_LOAD: if (func3 == 3'b010) begin
                    mem_read     = 1'b1;
                    mem_2_reg    = 1'b1;
                    reg_write    = 1'b1;
                    alu_src      = 1'b1;
                    wrt_back_src = 2'b00;
                end
                OP_STORE: if (func3 == 3'b010) begin
                    mem_write = 1'b1;
                    alu_src   = 1'b1;
                    imm_src   = 3'b001;
                end
                OP_BRANCH: begin
                    case (func3)
                        3'b000:  begin is_br = 1'b1; alu_ctrl = ALU_SUB; end
                        3'b001:  begin is_br = 1'b1; br_inv = 1'b1; alu_ctrl = ALU_SUB; end
                        3'b100:  begin is_br = 1'b1; br_inv = 1'b1; alu_ctrl = ALU_SLT; end
                        3'b101:  begin is_br = 1'b1; alu_ctrl = ALU_SLT; end
                        3'b110:  begin is_br = 1'b1; br_inv = 1'b1; alu_ctrl = ALU_SLTU; end
                        3'b111:  begin is_br = 1'b1; alu_ctrl = ALU_SLTU; end
                        default: ;
                    endcase
                    if (is_br) imm_src = 3'b010;
                end
                OP_JAL: begin
                    jump         = 1'b1;
                    reg_write    = 1'b1;
                    imm_src      = 3'b011;
                    wrt_back_src = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign op_b = alu_src ? imm : rs2;

    always_comb begin
        alu_result = rs1 + op_b;
        case (alu_ctrl)
            ALU_SUB:  alu_result = rs1 - op_b;
            ALU_AND:  alu_result = rs1 & op_b;
            ALU_OR:   alu_result = rs1 | op_b;
            ALU_XOR:  alu_result = rs1 ^ op_b;
            ALU_SLL:  alu_result = rs1 << op_b[4:0];
            ALU_SRL:  alu_result = rs1 >> op_b[4:0];
            ALU_SRA:  alu_result = $signed(rs1) >>> op_b[4:0];
            ALU_SLT:  alu_result = {31'b0, $signed(rs1) < $signed(op_b)};
            ALU_SLTU: alu_result = {31'b0, rs1 < op_b};
            default:  ;
        endcase
    end

    assign alu_zero = (alu_result == 32'd0);
    // A zero result means equal for SUB and "not less" for the compares.
    assign branch   = jump | (is_br & (alu_zero ^ br_inv));

    logic [31:0]           mem_q [DEPTH];
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_dat;

    assign wr_en   = init_mode ? ext_w_enb  : mem_write;
    assign wr_addr = init_mode ? ext_w_addr : alu_result[ADDR_WIDTH-1:0];
    assign wr_dat  = init_mode ? ext_w_dat  : rs2;

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wr_addr[ADDR_WIDTH-1:2]] <= wr_dat;
        end
    end

    assign mem_rdata = mem_read ? mem_q[alu_result[ADDR_WIDTH-1:2]] : 32'd0;

`ifdef RV32I_DEBUG_PORT_EN
    assign debug_data = mem_q[debug_addr[ADDR_WIDTH-1:2]];
    logic unused_dbg;
    assign unused_dbg = ^debug_addr[1:0];
`endif

    logic unused_bits;
    assign unused_bits = ^{instr[24:15], instr[11:7], alu_result[31:ADDR_WIDTH], wr_addr[1:0]};

endmodule

// File: tb/tb_rv32i_exec_mem_unit.sv
// Directed and random checks of rv32i_exec_mem_unit against a mnemonic-level reference model.
module tb_rv32i_exec_mem_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr, rs1, rs2, imm;
    logic        init_mode;
    logic [9:0]  ext_w_addr;
    logic [31:0] ext_w_dat;
    logic        ext_w_enb;
    logic        branch;
    logic [2:0]  imm_src;
    logic        mem_read, mem_write, mem_2_reg, alu_src, reg_write;
    logic [3:0]  alu_ctrl;
    logic [1:0]  wrt_back_src;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [31:0] mem_rdata;
`ifdef RV32I_DEBUG_PORT_EN
    logic [9:0]  debug_addr;
    logic [31:0] debug_data;
`endif

    rv32i_exec_mem_unit #(.ADDR_WIDTH(10), .DEPTH(256)) dut (
        .clk(clk), .rst(rst), .instr(instr), .rs1(rs1), .rs2(rs2), .imm(imm),
        .init_mode(init_mode), .ext_w_addr(ext_w_addr), .ext_w_dat(ext_w_dat), .ext_w_enb(ext_w_enb),
        .branch(branch), .imm_src(imm_src), .mem_read(mem_read), .mem_write(mem_write),
        .mem_2_reg(mem_2_reg), .alu_src(alu_src), .reg_write(reg_write), .alu_ctrl(alu_ctrl),
        .wrt_back_src(wrt_back_src), .alu_result(alu_result), .alu_zero(alu_zero), .mem_rdata(mem_rdata)
`ifdef RV32I_DEBUG_PORT_EN
        , .debug_addr(debug_addr), .debug_data(debug_data)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [31:0] I_LW  = 32'h00002283;
    localparam logic [31:0] I_BEQ = 32'h00628063;
    localparam logic [31:0] I_BNE = 32'h00629063;
    localparam logic [31:0] I_SW  = 32'h00702623;

    int total = 0;
    int bad   = 0;
    logic [31:0] ref_mem [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a % 32'd1024) / 32'd4);
    endfunction

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'h33};
    endfunction

    // Reads a word through a load instruction (and the debug port when built).
    task automatic read_check(input string tag, input logic [31:0] addr);
        init_mode = 1'b0;
        instr = I_LW;
        rs1 = addr;
        imm = 32'd0;
`ifdef RV32I_DEBUG_PORT_EN
        debug_addr = addr[9:0];
`endif
        #1;
        check(tag, mem_rdata, ref_mem[widx(addr)]);
`ifdef RV32I_DEBUG_PORT_EN
        check({tag, "_dbg"}, debug_data, ref_mem[widx(addr)]);
`endif
    endtask

    function automatic string mnem(input logic [31:0] i);
        logic alt;
        alt = (i[31:25] == 7'h20);
        case (i[6:0])
            7'h33, 7'h13: begin
                case (i[14:12])
                    3'd0: return (i[6:0] == 7'h33 && alt) ? "sub" : "add";
                    3'd1: return "sll";
                    3'd2: return "slt";
                    3'd3: return "sltu";
                    3'd4: return "xor";
                    3'd5: return alt ? "sra" : "srl";
                    3'd6: return "or";
                    default: return "and";
                endcase
            end
            7'h03: return (i[14:12] == 3'd2) ? "lw" : "none";
            7'h23: return (i[14:12] == 3'd2) ? "sw" : "none";
            7'h63: begin
                case (i[14:12])
                    3'd0: return "beq";
                    3'd1: return "bne";
                    3'd4: return "blt";
                    3'd5: return "bge";
                    3'd6: return "bltu";
                    3'd7: return "bgeu";
                    default: return "none";
                endcase
            end
            7'h6F: return "jal";
            default: return "none";
        endcase
    endfunction

    function automatic logic [31:0] ref_result(input string m, input logic [31:0] a, input logic [31:0] b);
        case (m)
            "sub", "beq", "bne":  return a - b;
            "and":                return a & b;
            "or":                 return a | b;
            "xor":                return a ^ b;
            "sll":                return a << b[4:0];
            "srl":                return a >> b[4:0];
            "sra":                return 32'($signed(a) >>> b[4:0]);
            "slt", "blt", "bge":  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            "sltu", "bltu", "bgeu": return (a < b) ? 32'd1 : 32'd0;
            default:              return a + b;
        endcase
    endfunction

    function automatic logic [3:0] ref_code(input string m);
        case (m)
            "sub", "beq", "bne":   return 4'd1;
            "and":                 return 4'd2;
            "or":                  return 4'd3;
            "xor":                 return 4'd4;
            "sll":                 return 4'd5;
            "srl":                 return 4'd6;
            "sra":                 return 4'd7;
            "slt", "blt", "bge":   return 4'd8;
            "sltu", "bltu", "bgeu": return 4'd9;
            default:               return 4'd0;
        endcase
    endfunction

    function automatic logic ref_taken(input string m, input logic [31:0] a, input logic [31:0] b);
        case (m)
            "jal":  return 1'b1;
            "beq":  return a == b;
            "bne":  return a != b;
            "blt":  return $signed(a) < $signed(b);
            "bge":  return $signed(a) >= $signed(b);
            "bltu": return a < b;
            "bgeu": return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    string       m;
    logic        is_br, use_imm, exp_rw;
    logic [2:0]  exp_isrc;
    logic [31:0] exp_res, exp_ctrl, dut_ctrl;
    logic [6:0]  opc;

    initial begin
        rst = 1'b1; instr = I_LW; rs1 = 32'd0; rs2 = 32'd0; imm = 32'd0;
        init_mode = 1'b0; ext_w_addr = '0; ext_w_dat = '0; ext_w_enb = 1'b0;
`ifdef RV32I_DEBUG_PORT_EN
        debug_addr = '0;
`endif
        #1;
        check("rst_ctrl", {19'b0, branch, imm_src, mem_read, mem_write, mem_2_reg, alu_src, reg_write, alu_ctrl}, 32'd0);
        check("rst_wb", {30'b0, wrt_back_src}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        tick();
        rst = 1'b0;

        // Fill the whole array so the model starts from known contents.
        init_mode = 1'b1; ext_w_enb = 1'b1; ext_w_dat = 32'd0;
        for (int i = 0; i < 256; i++) begin
            ext_w_addr = 10'(i * 4);
            ref_mem[i] = 32'd0;
            tick();
        end

        ext_w_addr = 10'h0; ext_w_dat = 32'h3; tick(); ref_mem[0] = 32'h3;
        ext_w_addr = 10'h4; ext_w_dat = 32'h3; tick(); ref_mem[1] = 32'h3;
        ext_w_addr = 10'h8; ext_w_dat = 32'h5; tick(); ref_mem[2] = 32'h5;
        ext_w_enb = 1'b0; ext_w_addr = 10'h0; ext_w_dat = 32'hFFFFFFFF;
        tick(); tick();
        read_check("init_w0", 32'h0);
        read_check("init_w1", 32'h4);
        read_check("init_w2", 32'h8);

        instr = I_LW; rs1 = 32'd0; imm = 32'd0; rs2 = 32'd0; init_mode = 1'b0;
        #1;
        check("lw_mem_read", {31'b0, mem_read}, 32'd1);
        check("lw_reg_write", {31'b0, reg_write}, 32'd1);
        check("lw_wb", {30'b0, wrt_back_src}, 32'd0);
        check("lw_result", alu_result, 32'd0);
        check("lw_rdata", mem_rdata, 32'h3);

        instr = I_BEQ; rs1 = 32'd3; rs2 = 32'd3; imm = 32'h10; #1;
        check("beq_ctrl", {28'b0, alu_ctrl}, 32'd1);
        check("beq_zero", {31'b0, alu_zero}, 32'd1);
        check("beq_taken", {31'b0, branch}, 32'd1);
        rs2 = 32'd5; #1;
        check("beq_not_taken", {31'b0, branch}, 32'd0);
        instr = I_BNE; #1;
        check("bne_taken", {31'b0, branch}, 32'd1);
        rs2 = 32'd3; #1;
        check("bne_not_taken", {31'b0, branch}, 32'd0);

        instr = I_SW; rs1 = 32'd0; rs2 = 32'd5; imm = 32'hC;
`ifdef RV32I_DEBUG_PORT_EN
        debug_addr = 10'hC;
`endif
        #1;
        check("sw_mem_write", {31'b0, mem_write}, 32'd1);
        check("sw_addr", alu_result, 32'hC);
        check("sw_rdata", mem_rdata, 32'd0);
`ifdef RV32I_DEBUG_PORT_EN
        check("sw_before_edge", debug_data, 32'd0);
`endif
        tick();
        ref_mem[3] = 32'h5;
`ifdef RV32I_DEBUG_PORT_EN
        check("sw_after_edge", debug_data, 32'h5);
`endif
        read_check("sw_readback", 32'hC);
        read_check("byte_offset", 32'hE);

        instr = I_SW; rs1 = 32'h400; imm = 32'h10; rs2 = 32'hA5A50001; #1;
        tick();
        ref_mem[4] = 32'hA5A50001;
        read_check("addr_wrap", 32'h10);

        instr = I_SW; rs1 = 32'h24; imm = 32'd0; rs2 = 32'h99;
        init_mode = 1'b1; ext_w_enb = 1'b1; ext_w_addr = 10'h20; ext_w_dat = 32'h77;
        tick();
        ref_mem[8] = 32'h77;
        ext_w_enb = 1'b0;
        read_check("init_prio_ext", 32'h20);
        read_check("init_prio_sw", 32'h24);

        rs1 = 32'hFFFFFFF8; rs2 = 32'd2; imm = 32'd0;
        instr = rtype(7'h20, 3'd5); #1; check("sra", alu_result, 32'hFFFFFFFE);
        instr = rtype(7'h00, 3'd5); #1; check("srl", alu_result, 32'h3FFFFFFE);
        instr = rtype(7'h00, 3'd2); #1; check("slt", alu_result, 32'd1);
        instr = rtype(7'h00, 3'd3); #1; check("sltu", alu_result, 32'd0);
        instr = rtype(7'h00, 3'd0); rs2 = 32'd8; #1;
        check("add_wrap", alu_result, 32'd0);
        check("add_zero", {31'b0, alu_zero}, 32'd1);

        tick();
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 8))
                0: opc = 7'h33;
                1: opc = 7'h13;
                2: opc = 7'h03;
                3: opc = 7'h23;
                4: opc = 7'h63;
                5: opc = 7'h6F;
                6: opc = 7'h37;
                7: opc = 7'h67;
                default: opc = 7'($urandom);
            endcase
            if (opc == 7'h03 && $urandom_range(0, 7) == 0 && n > 1000) opc = 7'h7F;
            instr = $urandom;
            instr[6:0] = opc;
            if (opc == 7'h03 || opc == 7'h23) instr[14:12] = 3'b010;
            if ($urandom_range(0, 1) == 1) instr[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            rs1 = $urandom; rs2 = $urandom; imm = $urandom;
            if ($urandom_range(0, 3) == 0) rs2 = rs1;
            init_mode = 1'b0;
            ext_w_enb = 1'b0;
            #1;
            m = mnem(instr);
            is_br = (m == "beq") || (m == "bne") || (m == "blt") || (m == "bge") || (m == "bltu") || (m == "bgeu");
            use_imm = (opc == 7'h13) || (m == "lw") || (m == "sw");
            exp_rw = (opc == 7'h33) || (opc == 7'h13) || (m == "lw") || (m == "jal");
            exp_isrc = (m == "sw") ? 3'd1 : is_br ? 3'd2 : (m == "jal") ? 3'd3 : 3'd0;
            exp_res = ref_result(m, rs1, use_imm ? imm : rs2);
            exp_ctrl = {19'b0, ref_taken(m, rs1, rs2), exp_isrc, m == "lw", m == "sw", m == "lw",
                        use_imm, exp_rw, ref_code(m)};
            dut_ctrl = {19'b0, branch, imm_src, mem_read, mem_write, mem_2_reg, alu_src, reg_write, alu_ctrl};
            check($sformatf("rnd_ctrl_%s", m), dut_ctrl, exp_ctrl);
            check($sformatf("rnd_result_%s", m), alu_result, exp_res);
            check($sformatf("rnd_rdata_%s", m), mem_rdata, (m == "lw") ? ref_mem[widx(exp_res)] : 32'd0);
            if (!is_br && m != "sw")
                check($sformatf("rnd_wb_%s", m), {30'b0, wrt_back_src},
                      (m == "lw") ? 32'd0 : (m == "jal") ? 32'd2 : 32'd1);
            if ($urandom_range(0, 3) == 0) begin
                init_mode = 1'b1;
                ext_w_enb = 1'($urandom_range(0, 1));
                ext_w_addr = 10'($urandom);
                ext_w_dat = $urandom;
                if (ext_w_enb) ref_mem[widx({22'b0, ext_w_addr})] = ext_w_dat;
            end else if (m == "sw") begin
                ref_mem[widx(exp_res)] = rs2;
            end
            tick();
        end
        init_mode = 1'b0; ext_w_enb = 1'b0;
        read_check("rnd_final_w3", 32'hC);

        rst = 1'b1; instr = I_SW; rs1 = 32'd0; imm = 32'd0; rs2 = 32'hDEADBEEF; #1;
        check("rst_sw_ctrl", {19'b0, branch, imm_src, mem_read, mem_write, mem_2_reg, alu_src, reg_write, alu_ctrl}, 32'd0);
        check("rst_sw_wb", {30'b0, wrt_back_src}, 32'd0);
        tick();
        init_mode = 1'b1; ext_w_enb = 1'b1; ext_w_addr = 10'h0; ext_w_dat = 32'hBAD;
        tick();
        instr = I_LW; init_mode = 1'b0; ext_w_enb = 1'b0; #1;
        check("rst_lw_rdata", mem_rdata, 32'd0);
        rst = 1'b0;
        read_check("rst_retain_w0", 32'h0);
        read_check("rst_retain_w2", 32'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32i_exec_mem_unit.md
# rv32i_exec_mem_unit

Single-cycle RV32I execute/memory slice: combinational main decoder (control), 32-bit ALU, and a word-organised data RAM with an initialisation write port and a debug read port. It sits between the register file/immediate generator and the write-back mux of the single-core CPU. It produces all datapath control strobes, the branch-taken decision, the ALU result and the load data within the same cycle.

## Interface
- ADDR_WIDTH, 10: byte-address bits seen by the data RAM.
- DEPTH, 256: RAM depth in 32-bit words; must equal 2^(ADDR_WIDTH-2).
- clk  in  1  clock; RAM writes occur on the rising edge.
- rst  in  1  reset; reset is synchronous and active-high.
- instr  in  32  current instruction word; opcode [6:0], func3 [14:12], func7 [31:25].
- rs1, rs2  in  32  register-file read data.
- imm  in  32  sign-extended immediate from the immediate generator.
- init_mode  in  1  1: the RAM write port is driven by the ext_w_* inputs. 0: the RAM write port is driven by the datapath.
- ext_w_addr  in  ADDR_WIDTH  initialisation byte address.
- ext_w_dat  in  32  initialisation write data.
- ext_w_enb  in  1  initialisation write enable.
- branch  out  1  PC select. 1 means the PC loads the branch/jump target.
- imm_src  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
- mem_read, mem_write, mem_2_reg, alu_src, reg_write  out  1 each  datapath strobes.
- alu_ctrl  out  4  ALU operation: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU.
- wrt_back_src  out  2  write-back source: 00 memory, 01 ALU, 10 PC+4.
- alu_result  out  32  ALU result.
- alu_zero  out  1  alu_result == 0.
- mem_rdata  out  32  load data.
- debug_addr  in  ADDR_WIDTH  debug byte address.
- debug_data  out  32  debug read data.

## Operation
- Decoder, by opcode:
  - R-type 0110011: reg_write=1, alu_src=0, wrt_back_src=01. func3/func7 select the operation: 000 ADD, or SUB if func7=0100000; 111 AND; 110 OR; 100 XOR; 001 SLL; 101 SRL, or SRA if func7=0100000; 010 SLT; 011 SLTU.
  - I-ALU 0010011: same mapping with alu_src=1 and imm_src=000. func7 is honoured only for the shift encoding 101.
  - LOAD 0000011 (LW): mem_read=1, mem_2_reg=1, reg_write=1, alu_src=1, ADD, wrt_back_src=00.
  - STORE 0100011 (SW): mem_write=1, alu_src=1, imm_src=001, ADD.
  - BRANCH 1100011: imm_src=010, alu_src=0. beq and bne use SUB. blt and bge use SLT. bltu and bgeu use SLTU.
    - branch = alu_zero for beq, bge, bgeu.
    - branch = !alu_zero for bne, blt, bltu.
  - JAL 1101111: branch=1, reg_write=1, imm_src=011, wrt_back_src=10.
  - Any other opcode or func3 (including LUI, AUIPC, JALR): every strobe is 0, alu_ctrl=ADD, imm_src=000, wrt_back_src=01.
- ALU operands:
  - Operand A is rs1. Operand B is imm when alu_src=1, otherwise rs2.
  - Shift amount is B[4:0].
  - SLT is a signed compare and SLTU is unsigned; both produce 0 or 1.
  - Arithmetic wraps modulo 2^32.
- RAM write port:
  - init_mode=1: addr=ext_w_addr, data=ext_w_dat, enable=ext_w_enb.
  - init_mode=0: addr=alu_result[ADDR_WIDTH-1:0], data=rs2, enable=mem_write.
- RAM read:
  - Read address is alu_result[ADDR_WIDTH-1:0].
  - mem_rdata = mem[word index] when mem_read=1, else 0.
- RAM addressing:
  - The word index is addr[ADDR_WIDTH-1:2]. Byte-offset bits [1:0] are ignored.
  - Address bits above ADDR_WIDTH are ignored, so addresses wrap modulo DEPTH.
- Debug read: debug_data = mem[debug_addr[ADDR_WIDTH-1:2]]. It is unconditional and combinational.

## Timing
- The decoder, ALU, mem_rdata and debug_data are purely combinational, with zero-cycle latency.
- A RAM write commits on the rising clk edge when enable=1 and rst=0. The written data is readable immediately after that edge.
- Read of an address during a cycle that writes it: returns the old word until the edge, then the new word. There is no bypass.
- While rst=1:
  - All decoder outputs are forced to 0; alu_ctrl=ADD.
  - mem_rdata = 0.
  - RAM writes are suppressed.
  - RAM contents are retained; reset never clears the array.
- After reset deasserts, outputs follow the inputs in the same cycle.
- Power-up RAM contents are undefined; simulation models initialise them to 0.
- Switching init_mode takes effect for the next clock edge. init_mode=1 and mem_write=1 together: only the ext_w_* port writes.

## Configuration
- RV32I_DEBUG_PORT_EN defined: the debug_addr/debug_data ports and the combinational debug read exist.
- RV32I_DEBUG_PORT_EN undefined: both ports are absent and no debug read logic is built. All other behaviour is identical.

## Test plan
- Init load: with init_mode=1, write 0x3, 0x3, 0x5 at addresses 0x0, 0x4, 0x8. debug_data then returns each word, and ext_w_enb=0 cycles leave the contents unchanged.
- LW: init_mode=0, instr=lw x5,0(x0) (0x00002283), rs1=0, imm=0. Required: mem_read=1, reg_write=1, wrt_back_src=00, alu_result=0, mem_rdata=0x3.
- BEQ taken/not taken: instr=beq x5,x6 (func3 000), rs1=3, rs2=3 gives alu_ctrl=SUB, alu_zero=1, branch=1. With rs2=5, branch=0. bne with the same operands gives the inverse.
- SW: instr=sw x7,0xC(x0), rs2=5, imm=0xC. After one edge, debug_data at 0xC = 0x00000005. mem_rdata is unchanged before the edge.
- ALU ops: rs1=0xFFFFFFF8, rs2=2.
  - SRA → 0xFFFFFFFE.
  - SRL → 0x3FFFFFFE.
  - SLT → 1.
  - SLTU → 0.
  - ADD with rs2=8 → 0, with alu_zero=1.
- Reset: assert rst with mem_write=1. No write occurs, all strobes read 0, and previously loaded RAM data is intact after release.
